// File: rtl/inv_key_expansion_if.sv
// Key-schedule handshake bundle between the key register / controller and the inverse round engine.
// master drives start/key_in/key_ready; slave (the key schedule) drives the round-key side.
interface inv_key_expansion_if;
    logic         start;
    logic [127:0] key_in;
    logic         key_ready;
    logic         key_valid;
    logic [127:0] round_key_o;
    logic [3:0]   round_o;
    logic         last_o;
    logic         busy;

    modport master (
        output start, key_in, key_ready,
        input  key_valid, round_key_o, round_o, last_o, busy
    );

    modport slave (
        input  start, key_in, key_ready,
        output key_valid, round_key_o, round_o, last_o, busy
    );
endinterface

// File: rtl/inv_key_expansion.sv
// Reverse AES-128 key schedule: round keys 10..0 from the round-10 key, one byte-serial S-box (INV_KEY_MIXCOL_EN: InvMixColumns on rounds 9..1).
// Latency: first key 1 cycle after start; next key 6 cycles after each handshake cycle.
// Backpressure: key_valid and all outputs hold stable until key_ready; nothing is recomputed while stalled.
module inv_key_expansion (
    input  logic               clk,
    input  logic               rst,
    inv_key_expansion_if.slave kif
);
    typedef enum logic [1:0] {IDLE, OUT, SUB, UPD} state_t;

    state_t      state, state_nxt;
    logic [31:0] w0, w1, w2, w3;
    logic [3:0]  rnd;
    logic [1:0]  cnt;
    logic [7:0]  sub [4];

    logic [31:0] prev_w3;
    logic [31:0] rot_w;
    logic [7:0]  sbox_in;
    logic [7:0]  sbox_out;
    logic [31:0] g;
    logic        load;
    logic        accept;
    logic        key_valid;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (square-and-multiply), then the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

`ifdef INV_KEY_MIXCOL_EN
    function automatic logic [31:0] inv_mix_word(input logic [31:0] wd);
        logic [7:0] a0, a1, a2, a3;
        a0 = wd[31:24];
        a1 = wd[23:16];
        a2 = wd[15:8];
        a3 = wd[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (kif.start) begin
                    load      = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (kif.key_ready) begin
                    accept    = 1'b1;
                    state_nxt = (rnd == 4'd0) ? IDLE : SUB;
                end
            end
            SUB: begin
                if (cnt == 2'd3) state_nxt = UPD;
            end
            UPD: begin
                state_nxt = OUT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // w2^w3 recovers the previous round's w3, which fed that round's g-function.
    assign prev_w3 = w2 ^ w3;
    assign rot_w   = {prev_w3[23:0], prev_w3[31:24]};

    always_comb begin
        sbox_in = rot_w[31:24];
        case (cnt)
            2'd0:    sbox_in = rot_w[31:24];
            2'd1:    sbox_in = rot_w[23:16];
            2'd2:    sbox_in = rot_w[15:8];
            default: sbox_in = rot_w[7:0];
        endcase
    end

    assign sbox_out = sbox(sbox_in);
    assign g        = {sub[0] ^ rcon_of(rnd), sub[1], sub[2], sub[3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            w0     <= '0;
            w1     <= '0;
            w2     <= '0;
            w3     <= '0;
            rnd    <= '0;
            cnt    <= '0;
            sub[0] <= '0;
            sub[1] <= '0;
            sub[2] <= '0;
            sub[3] <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                w0  <= kif.key_in[127:96];
                w1  <= kif.key_in[95:64];
                w2  <= kif.key_in[63:32];
                w3  <= kif.key_in[31:0];
                rnd <= 4'd10;
            end
            if (accept) cnt <= 2'd0;
            if (state == SUB) begin
                sub[cnt] <= sbox_out;
                cnt      <= cnt + 2'd1;
            end
            if (state == UPD) begin
                w0  <= w0 ^ g;
                w1  <= w0 ^ w1;
                w2  <= w1 ^ w2;
                w3  <= w2 ^ w3;
                rnd <= rnd - 4'd1;
            end
        end
    end

    assign key_valid     = (state == OUT);
    assign kif.key_valid = key_valid;
    assign kif.busy      = (state != IDLE);
    assign kif.round_o   = rnd;
    assign kif.last_o    = key_valid & (rnd == 4'd0);

`ifdef INV_KEY_MIXCOL_EN
    // Equivalent-inverse-cipher keys; w itself stays raw so the schedule keeps running backwards.
    assign kif.round_key_o = (rnd != 4'd0 && rnd != 4'd10) ?
                             {inv_mix_word(w0), inv_mix_word(w1), inv_mix_word(w2), inv_mix_word(w3)} :
                             {w0, w1, w2, w3};
`else
    assign kif.round_key_o = {w0, w1, w2, w3};
`endif
endmodule
